// File: rtl/imem_boot_ctrl.sv
// Boot-time instruction memory sequencer: zero-fills the single-port memory, streams
// a program in from the loader port, then hands the read port to instruction fetch.
module imem_boot_ctrl #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ld_start,
  input  logic              i_ld_valid,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ld_last,
  output logic              o_ld_ready,
  input  logic [31:0]       i_cpu_addr,
  output logic [DATA_W-1:0] o_cpu_inst,
  output logic              o_cpu_stall,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic [ADDR_W:0]   o_word_count
);

  localparam logic [DATA_W-1:0] NOP      = DATA_W'(32'h0000_0013);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_word_count;
  logic                r_load_done;
  logic                r_load_err;
  logic                w_ptr_last;
  logic [ADDR_W-1:0]   w_fetch_addr;
  logic                w_unused_addr_bits;

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + (ADDR_W + 1)'(1);
  endfunction

  assign w_ptr_last         = (r_ptr == PTR_LAST);
  assign w_fetch_addr       = i_cpu_addr[ADDR_W+1:2];
  assign w_unused_addr_bits = ^{i_cpu_addr[31:ADDR_W+2], i_cpu_addr[1:0]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ld_ready  = 1'b0;
    o_cpu_stall = 1'b1;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_cpu_inst  = NOP;
    case (r_state)
      S_BOOT: begin
        if (i_ld_start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        o_mem_we   = 1'b1;
        o_mem_addr = r_ptr;
        if (w_ptr_last) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        o_ld_ready  = 1'b1;
        o_mem_addr  = r_ptr;
        o_mem_wdata = i_ld_data;
        o_mem_we    = i_ld_valid;
        // The final memory word ends the load even without ld_last (overflow).
        if (i_ld_valid && (i_ld_last || w_ptr_last)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        o_cpu_stall = 1'b0;
        o_mem_addr  = w_fetch_addr;
        o_cpu_inst  = i_mem_rdata;
        if (i_ld_start) w_state_nxt = S_CLEAR;
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr        <= '0;
      r_word_count <= '0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_load_done <= (r_state == S_LOAD) && (w_state_nxt == S_RUN);
      case (r_state)
        S_BOOT, S_RUN: begin
          if (i_ld_start) begin
            r_ptr        <= '0;
            r_word_count <= '0;
            r_load_err   <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_ptr <= r_ptr + ADDR_W'(1);
        end
        S_LOAD: begin
          if (i_ld_valid) begin
            r_ptr        <= r_ptr + ADDR_W'(1);
            r_word_count <= sat_inc(r_word_count);
            if (w_ptr_last && !i_ld_last) r_load_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_load_done  = r_load_done;
  assign o_load_err   = r_load_err;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl with a 16-word memory model and an expected-image scoreboard.
module tb_imem_boot_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_start, ld_valid, ld_last;
  logic [31:0]   ld_data, cpu_addr, cpu_inst, mem_wdata, mem_rdata;
  logic          ld_ready, cpu_stall, mem_we, load_done, load_err;
  logic [AW-1:0] mem_addr;
  logic [AW:0]   word_count;
  logic          scramble;

  logic [31:0]   mem     [DEPTH];
  logic [31:0]   exp_mem [DEPTH];
  logic [31:0]   prog    [$];
  int            exp_cnt;
  bit            exp_err;
  int            checks = 0;
  int            errors = 0;

  imem_boot_ctrl #(.MEM_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_ld_start(ld_start), .i_ld_valid(ld_valid),
    .i_ld_data(ld_data), .i_ld_last(ld_last), .o_ld_ready(ld_ready),
    .i_cpu_addr(cpu_addr), .o_cpu_inst(cpu_inst), .o_cpu_stall(cpu_stall),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_load_done(load_done), .o_load_err(load_err),
    .o_word_count(word_count)
  );

  always #5 clk = ~clk;

  // Memory array: synchronous write, asynchronous read; scramble fills it with junk.
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit from_run);
    ld_start = 1'b1;
    ld_valid = from_run ? 1'b1 : 1'($urandom % 2);
    ld_data  = $urandom;
    ld_last  = 1'($urandom % 2);
    #2;
    chk("start_ready", ld_ready, 0);
    chk("start_we", mem_we, 0);
    chk("start_stall", cpu_stall, from_run ? 0 : 1);
    cyc();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
    exp_cnt = 0;
    exp_err = 1'b0;
    chk("clr_cnt", word_count, 0);
    chk("clr_err", load_err, 0);
    chk("clr_stall", cpu_stall, 1);
    for (int i = 0; i < DEPTH; i++) begin
      ld_start = 1'($urandom % 2);
      ld_valid = 1'($urandom % 2);
      #2;
      chk($sformatf("clr_we%0d", i), mem_we, 1);
      chk($sformatf("clr_addr%0d", i), mem_addr, i);
      chk($sformatf("clr_wdata%0d", i), mem_wdata, 0);
      chk($sformatf("clr_rdy%0d", i), ld_ready, 0);
      chk($sformatf("clr_inst%0d", i), cpu_inst, 32'h13);
      cyc();
    end
    ld_start = 1'b0;
    ld_valid = 1'b0;
  endtask

  // reset_at >= 0 asserts reset between edges once that many words have been accepted.
  task automatic do_load(input bit use_last, input bit gaps, input int reset_at);
    int idx = 0;
    int c   = 0;
    bit v;
    bit pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    while (idx < prog.size() && idx < DEPTH && c < 400) begin
      v        = gaps ? ((c < 5) ? pat[c] : 1'($urandom % 2)) : 1'b1;
      ld_valid = v;
      ld_data  = prog[idx];
      ld_last  = use_last && (idx == prog.size() - 1);
      ld_start = 1'($urandom % 2);
      #2;
      chk("ld_ready", ld_ready, 1);
      chk($sformatf("ld_addr%0d", idx), mem_addr, idx);
      chk("ld_we", mem_we, v);
      chk("ld_wdata", mem_wdata, prog[idx]);
      chk("ld_stall", cpu_stall, 1);
      if (reset_at >= 0 && idx == reset_at) begin
        reset = 1'b1;
        #1;
        chk("rst_stall", cpu_stall, 1);
        chk("rst_cnt", word_count, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        return;
      end
      cyc();
      c++;
      if (v) begin
        exp_mem[idx] = prog[idx];
        idx++;
      end
    end
    if (c >= 400) begin
      checks++;
      errors++;
      $error("FAIL load_budget observed=%0d expected=below_400", c);
    end
    ld_start = 1'b0;
    exp_cnt  = idx;
    exp_err  = (idx == DEPTH) && !(use_last && idx == prog.size());
    if (prog.size() > idx) begin
      ld_valid = 1'b1;
      ld_data  = prog[idx];
    end else begin
      ld_valid = 1'b0;
    end
    #2;
    chk("run_done", load_done, 1);
    chk("run_stall", cpu_stall, 0);
    chk("run_ready", ld_ready, 0);
    chk("run_we", mem_we, 0);
    chk("run_cnt", word_count, exp_cnt);
    chk("run_err", load_err, exp_err);
    cyc();
    ld_valid = 1'b0;
    #2;
    chk("run_done_pulse", load_done, 0);
    chk("run_cnt_hold", word_count, exp_cnt);
    chk("run_err_hold", load_err, exp_err);
    cyc();
  endtask

  task automatic check_fetch();
    logic [31:0] r;
    logic [AW-1:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom;
      a = AW'(i);
      cpu_addr = {r[31:6], a, r[1:0]};
      #2;
      chk($sformatf("fetch%0d", i), cpu_inst, exp_mem[i]);
      chk("fetch_stall", cpu_stall, 0);
      cyc();
    end
  endtask

  initial begin
    int n;
    bit ul;
    reset    = 1'b1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = 32'h0;
    cpu_addr = 32'h0;
    scramble = 1'b1;
    #1;
    chk("rst0_stall", cpu_stall, 1);
    chk("rst0_cnt", word_count, 0);
    repeat (2) cyc();
    scramble = 1'b0;
    reset    = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cpu_addr = $urandom;
      #2;
      chk("idle_stall", cpu_stall, 1);
      chk("idle_ready", ld_ready, 0);
      chk("idle_we", mem_we, 0);
      chk("idle_addr", mem_addr, 0);
      chk("idle_inst", cpu_inst, 32'h13);
      chk("idle_done", load_done, 0);
      chk("idle_err", load_err, 0);
      cyc();
    end

    prog = '{32'h00500093, 32'h00108113, 32'h00000073};
    do_start(1'b0);
    do_load(1'b1, 1'b0, -1);
    cpu_addr = 32'h8;
    #2;
    chk("fetch_0x8", cpu_inst, 32'h00000073);
    cyc();
    cpu_addr = 32'hC;
    #2;
    chk("fetch_0xC", cpu_inst, 32'h0);
    cyc();
    check_fetch();

    prog.delete();
    repeat (5) prog.push_back($urandom);
    do_start(1'b1);
    do_load(1'b1, 1'b1, -1);
    check_fetch();

    prog.delete();
    repeat (17) prog.push_back($urandom);
    do_start(1'b1);
    do_load(1'b0, 1'b0, -1);
    check_fetch();

    prog = '{32'h00500093, 32'h00108113, 32'h00000073};
    do_start(1'b1);
    do_load(1'b1, 1'b0, -1);
    check_fetch();

    prog.delete();
    repeat (6) prog.push_back($urandom);
    do_start(1'b1);
    do_load(1'b1, 1'b0, 3);
    cyc();
    reset = 1'b0;
    #2;
    chk("post_rst_stall", cpu_stall, 1);
    chk("post_rst_inst", cpu_inst, 32'h13);
    cyc();

    for (int k = 0; k < 3; k++) begin
      n  = $urandom_range(1, 18);
      ul = (n <= DEPTH) ? 1'b1 : 1'($urandom % 2);
      prog.delete();
      repeat (n) prog.push_back($urandom);
      do_start(k != 0);
      do_load(ul, 1'($urandom % 2), -1);
      check_fetch();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
